// File: rtl/memoria_param_pkg.sv
// Shared definitions for the parametrised data memory.
//   - state encoding for the clear/run sequencer
//   - write-echo mode constants
//   - parameter legality check used at elaboration time
package memoria_param_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;

    // Only latencies of 1 or 2 are supported, and the implemented depth must
    // fit in the address space.
    function automatic bit params_legal(int rd_lat, int depth, int addr_w);
        return ((rd_lat == 1) || (rd_lat == 2)) && (depth >= 1) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/memoria_param_pipe.sv
// Result delivery delay line for memoria_param.
// RD_LAT register stages carrying {valid, err, data}. Each stage's data only
// loads when a valid result reaches it, so the last stage holds its value
// between results. Synchronous flush on rst.
// Ports:
//   clk, rst              clock, synchronous active-high flush
//   in_valid/in_err/in_data    combinational result of the accept cycle
//   out_valid/out_err/out_data registered result, RD_LAT edges later
module memoria_param_pipe #(
    parameter int DATA_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] err_q, err_d;
    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [DATA_W-1:0] data_d [RD_LAT];

    // Stage inputs: entry 0 is the new result, entry i+1 is stage i's output.
    logic [RD_LAT:0]   v_chain, e_chain;
    logic [DATA_W-1:0] d_chain [RD_LAT+1];

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        v_chain[0] = in_valid;
        e_chain[0] = in_valid & in_err;
        d_chain[0] = in_data;
        for (int i = 0; i < RD_LAT; i++) begin
            v_chain[i+1] = valid_q[i];
            e_chain[i+1] = err_q[i];
            d_chain[i+1] = data_q[i];
        end
        for (int i = 0; i < RD_LAT; i++) begin
            valid_d[i] = v_chain[i];
            err_d[i]   = e_chain[i];
            data_d[i]  = v_chain[i] ? d_chain[i] : data_q[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/memoria_param.sv
// Parametrised single-port data memory with a reset-time clear sequencer,
// configurable read latency, selectable write echo and out-of-range flagging.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en, we        access request / write select (sampled on rising edge)
//   add, data_in  word address / write data
//   data_out      read or echo data, holds between results
//   rd_valid      one-cycle pulse when data_out is new
//   err           one-cycle pulse with rd_valid: access was out of range
//   ready         high once the clear sequence has finished
module memoria_param
    import memoria_param_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              err,
    output logic              ready
);

    generate
        if (!params_legal(RD_LAT, DEPTH, ADDR_W)) begin : g_param_err
            $error("memoria_param: RD_LAT must be 1 or 2 and DEPTH must fit in ADDR_W");
        end
    endgenerate

    // Wider than add so DEPTH == 2**ADDR_W is representable; then in_range is always 1.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    // NOTE: the array has no reset; the clear sequencer zeroes it after every rst.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range;
    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              res_err;
    logic [DATA_W-1:0] res_data;

    assign in_range = ({1'b0, add} < DEPTH_L);
    assign accept   = (state_q == ST_RUN) && en;

    // Sequencer: walk cnt through 0..DEPTH-1 in CLEAR, then stay in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Single write port shared by the clear sequencer and user writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = add;
        wr_data = data_in;
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
            end else if (accept && we && in_range) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // The array is read before the accept edge's write lands, which gives the
    // read-first echo for free; write-first substitutes data_in.
    always_comb begin
        res_err  = ~in_range;
        res_data = '0;
        if (in_range) begin
            if (we && (WR_MODE == WR_WRITE_FIRST)) res_data = data_in;
            else                                  res_data = mem_q[add];
        end
    end

    memoria_param_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_err    (res_err),
        .in_data   (res_data),
        .out_valid (rd_valid),
        .out_err   (err),
        .out_data  (data_out)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_memoria_param.sv
// Directed bench for memoria_param. Four instances share one stimulus stream:
// default, write-first echo, DEPTH=24, and RD_LAT=2.
module tb_memoria_param;

    localparam int DW = 14;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, en, we;
    logic [AW-1:0] add;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout_a, dout_w, dout_d, dout_l;
    logic          vld_a, vld_w, vld_d, vld_l;
    logic          err_a, err_w, err_d, err_l;
    logic          rdy_a, rdy_w, rdy_d, rdy_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memoria_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .RD_LAT(1), .WR_MODE(0)) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .add(add), .data_in(data_in),
        .data_out(dout_a), .rd_valid(vld_a), .err(err_a), .ready(rdy_a));

    memoria_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .RD_LAT(1), .WR_MODE(1)) dut_wf (
        .clk(clk), .rst(rst), .en(en), .we(we), .add(add), .data_in(data_in),
        .data_out(dout_w), .rd_valid(vld_w), .err(err_w), .ready(rdy_w));

    memoria_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(24), .RD_LAT(1), .WR_MODE(0)) dut_d24 (
        .clk(clk), .rst(rst), .en(en), .we(we), .add(add), .data_in(data_in),
        .data_out(dout_d), .rd_valid(vld_d), .err(err_d), .ready(rdy_d));

    memoria_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .RD_LAT(2), .WR_MODE(0)) dut_l2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .add(add), .data_in(data_in),
        .data_out(dout_l), .rd_valid(vld_l), .err(err_l), .ready(rdy_l));

    // Advance one rising edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic w, input int a, input int d);
        en      = e;
        we      = w;
        add     = AW'(a);
        data_in = DW'(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 0, 0);
        step();
        step();
        n_checks++;
        if ({rdy_a, vld_a, err_a, dout_a} !== {3'b000, 14'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b err=%b dout=%0d, need 0 0 0 0", rdy_a, vld_a, err_a, dout_a);
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_checks++;
            if (rdy_a !== (k == 32)) begin
                n_fail++;
                $display("FAIL clear_ready edge %0d: got %b need %b", k, rdy_a, (k == 32));
            end
            n_checks++;
            if (vld_a !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_no_valid edge %0d: got %b need 0", k, vld_a);
            end
            if (k == 23 || k == 24) begin
                n_checks++;
                if (rdy_d !== (k == 24)) begin
                    n_fail++;
                    $display("FAIL clear_ready_d24 edge %0d: got %b need %b", k, rdy_d, (k == 24));
                end
            end
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_cleared_reads();
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, a, 0);
            step();
            n_checks++;
            if ({vld_a, err_a, dout_a} !== {2'b10, 14'd0}) begin
                n_fail++;
                $display("FAIL cleared_read add %0d: vld=%b err=%b dout=%0d, need 1 0 0", a, vld_a, err_a, dout_a);
            end
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_write_read();
        drive(1, 1, 23, 20);
        step();
        n_checks++;
        if ({vld_a, dout_a} !== {1'b1, 14'd0}) begin
            n_fail++;
            $display("FAIL write_echo_rf: vld=%b dout=%0d, need 1 0", vld_a, dout_a);
        end
        n_checks++;
        if ({vld_w, dout_w} !== {1'b1, 14'd20}) begin
            n_fail++;
            $display("FAIL write_echo_wf: vld=%b dout=%0d, need 1 20", vld_w, dout_w);
        end
        drive(1, 0, 23, 0);
        step();
        n_checks++;
        if ({vld_a, err_a, dout_a} !== {2'b10, 14'd20}) begin
            n_fail++;
            $display("FAIL raw_read: vld=%b err=%b dout=%0d, need 1 0 20", vld_a, err_a, dout_a);
        end
        drive(0, 0, 0, 0);
        step();
        n_checks++;
        if ({vld_a, dout_a} !== {1'b0, 14'd20}) begin
            n_fail++;
            $display("FAIL pulse_and_hold: vld=%b dout=%0d, need 0 20", vld_a, dout_a);
        end
    endtask

    task automatic test_echo_modes();
        drive(1, 1, 23, 5);
        step();
        n_checks++;
        if (dout_a !== 14'd20) begin
            n_fail++;
            $display("FAIL echo_read_first: got %0d need 20", dout_a);
        end
        n_checks++;
        if (dout_w !== 14'd5) begin
            n_fail++;
            $display("FAIL echo_write_first: got %0d need 5", dout_w);
        end
        drive(1, 0, 23, 0);
        step();
        n_checks++;
        if ({dout_a, dout_w} !== {14'd5, 14'd5}) begin
            n_fail++;
            $display("FAIL reread_both_modes: got %0d/%0d need 5/5", dout_a, dout_w);
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 25, 7);
        step();
        n_checks++;
        if ({vld_d, err_d, dout_d} !== {2'b11, 14'd0}) begin
            n_fail++;
            $display("FAIL oor_write: vld=%b err=%b dout=%0d, need 1 1 0", vld_d, err_d, dout_d);
        end
        drive(1, 0, 25, 0);
        step();
        n_checks++;
        if ({vld_d, err_d, dout_d} !== {2'b11, 14'd0}) begin
            n_fail++;
            $display("FAIL oor_read25: vld=%b err=%b dout=%0d, need 1 1 0", vld_d, err_d, dout_d);
        end
        n_checks++;
        if ({err_a, dout_a} !== {1'b0, 14'd7}) begin
            n_fail++;
            $display("FAIL full_depth_read25: err=%b dout=%0d, need 0 7", err_a, dout_a);
        end
        drive(1, 0, 24, 0);
        step();
        n_checks++;
        if ({vld_d, err_d} !== 2'b11) begin
            n_fail++;
            $display("FAIL oor_read24: vld=%b err=%b, need 1 1", vld_d, err_d);
        end
        drive(1, 0, 23, 0);
        step();
        n_checks++;
        if ({vld_d, err_d, dout_d} !== {2'b10, 14'd5}) begin
            n_fail++;
            $display("FAIL inrange_read23: vld=%b err=%b dout=%0d, need 1 0 5", vld_d, err_d, dout_d);
        end
        drive(0, 0, 0, 0);
        step();
        n_checks++;
        if ({vld_d, err_d} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_pulse_end: vld=%b err=%b, need 0 0", vld_d, err_d);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 1, 11);
        step();
        drive(1, 1, 2, 22);
        step();
        drive(1, 1, 3, 33);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        drive(1, 0, 1, 0);
        step();
        n_checks++;
        if (vld_l !== 1'b0) begin
            n_fail++;
            $display("FAIL lat2_first_edge: vld=%b need 0", vld_l);
        end
        drive(1, 0, 2, 0);
        step();
        n_checks++;
        if ({vld_l, dout_l} !== {1'b1, 14'd11}) begin
            n_fail++;
            $display("FAIL lat2_res1: vld=%b dout=%0d, need 1 11", vld_l, dout_l);
        end
        drive(1, 0, 3, 0);
        step();
        n_checks++;
        if ({vld_l, dout_l} !== {1'b1, 14'd22}) begin
            n_fail++;
            $display("FAIL lat2_res2: vld=%b dout=%0d, need 1 22", vld_l, dout_l);
        end
        drive(0, 0, 0, 0);
        step();
        n_checks++;
        if ({vld_l, dout_l} !== {1'b1, 14'd33}) begin
            n_fail++;
            $display("FAIL lat2_res3: vld=%b dout=%0d, need 1 33", vld_l, dout_l);
        end
        step();
        n_checks++;
        if ({vld_l, dout_l} !== {1'b0, 14'd33}) begin
            n_fail++;
            $display("FAIL lat2_hold: vld=%b dout=%0d, need 0 33", vld_l, dout_l);
        end
    endtask

    task automatic test_reset_mid_op();
        int edges;
        drive(1, 1, 23, 20);
        step();
        drive(1, 0, 23, 0);
        step();
        n_checks++;
        if ({vld_a, dout_a} !== {1'b1, 14'd20}) begin
            n_fail++;
            $display("FAIL pre_reset_read: vld=%b dout=%0d, need 1 20", vld_a, dout_a);
        end
        rst = 1'b1;
        drive(0, 0, 0, 0);
        step();
        n_checks++;
        if ({vld_a, vld_l, rdy_a, dout_a} !== {3'b000, 14'd0}) begin
            n_fail++;
            $display("FAIL reset_flush: vld=%b vld_l2=%b rdy=%b dout=%0d, need 0 0 0 0", vld_a, vld_l, rdy_a, dout_a);
        end
        // Partway into the clear, reset again: the counter must restart.
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        edges = 0;
        while (rdy_a !== 1'b1 && edges < 100) begin
            step();
            edges++;
        end
        n_checks++;
        if (edges !== 32) begin
            n_fail++;
            $display("FAIL clear_restart: ready after %0d edges, need 32", edges);
        end
        drive(1, 0, 23, 0);
        step();
        n_checks++;
        if ({vld_a, err_a, dout_a} !== {2'b10, 14'd0}) begin
            n_fail++;
            $display("FAIL post_reset_read: vld=%b err=%b dout=%0d, need 1 0 0", vld_a, err_a, dout_a);
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        test_reset();
        test_cleared_reads();
        test_write_read();
        test_echo_modes();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
